// File: rtl/led_chain_driver.sv
// Serial driver for shift-register LED chains: per-LED off/on/blink modes,
// request/ack frame writes, and automatic refresh whenever the blink phase flips.
module led_chain_driver #(
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned SLOT_BITS  = 2,
    parameter int unsigned CLK_DIV    = 32,
    parameter int unsigned BLINK_LOG2 = 23
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [2*NUM_LEDS-1:0]   led_mode,
    input  logic                    write_request,
    output logic                    write_ack,
    output logic                    busy,
    input  logic                    blank,
    output logic                    led_sck,
    output logic                    led_sin,
    output logic                    led_lat,
    output logic                    led_blk
);

    localparam int unsigned FRAME_BITS = NUM_LEDS * SLOT_BITS;
    localparam int unsigned DIV_W      = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        GAP
    } state_t;

    state_t                  state;
    logic [2*NUM_LEDS-1:0]   shadow;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [FRAME_BITS-1:0]   frame;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BLINK_LOG2-1:0]   blink_cnt;
    logic                    phase;
    logic                    refresh_pending;
    logic                    first_latched;
    logic                    blink_used;
    logic                    phase_toggle;
    logic                    div_done;
    logic                    latch_end;

    assign phase_toggle = &blink_cnt;
    assign div_done     = (div_cnt == '0);
    assign latch_end    = (state == LATCH) && div_done;

    // LED i lands in the LSB of slot i; slot 0 is shifted out first.
    always_comb begin
        frame = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            frame[(NUM_LEDS-1-i)*SLOT_BITS] = shadow[2*i+1] ? (phase ^ shadow[2*i]) : shadow[2*i];
        end
    end

    always_comb begin
        blink_used = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            blink_used = blink_used | shadow[2*i+1];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (phase_toggle) begin
                phase <= ~phase;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            shadow          <= '0;
            shift_reg       <= '0;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            refresh_pending <= 1'b0;
            first_latched   <= 1'b0;
            write_ack       <= 1'b0;
            busy            <= 1'b0;
            led_sck         <= 1'b0;
            led_sin         <= 1'b0;
            led_lat         <= 1'b0;
            led_blk         <= 1'b1;
        end else begin
            write_ack <= 1'b0;
            led_blk   <= (first_latched || latch_end) ? blank : 1'b1;

            // A toggle landing on the LOAD edge still schedules a refresh,
            // since the frame being built uses the pre-toggle phase.
            if (state == LOAD) begin
                refresh_pending <= 1'b0;
            end
            if (phase_toggle && blink_used) begin
                refresh_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (write_request) begin
                        shadow    <= led_mode;
                        write_ack <= 1'b1;
                        busy      <= 1'b1;
                        div_cnt   <= DIV_RELOAD;
                        state     <= LOAD;
                    end else if (refresh_pending) begin
                        busy    <= 1'b1;
                        div_cnt <= DIV_RELOAD;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg <= frame << 1;
                    led_sin   <= frame[FRAME_BITS-1];
                    led_sck   <= 1'b0;
                    bit_cnt   <= '0;
                    div_cnt   <= DIV_RELOAD;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (!led_sck) begin
                        led_sck <= 1'b1;
                        div_cnt <= DIV_RELOAD;
                    end else if (bit_cnt == LAST_BIT) begin
                        led_sck <= 1'b0;
                        led_sin <= 1'b0;
                        led_lat <= 1'b1;
                        div_cnt <= DIV_RELOAD;
                        state   <= LATCH;
                    end else begin
                        led_sck   <= 1'b0;
                        led_sin   <= shift_reg[FRAME_BITS-1];
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        div_cnt   <= DIV_RELOAD;
                    end
                end
                LATCH: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        led_lat       <= 1'b0;
                        first_latched <= 1'b1;
                        div_cnt       <= DIV_RELOAD;
                        state         <= GAP;
                    end
                end
                GAP: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        div_cnt <= DIV_RELOAD;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_chain_driver.sv
// Scoreboard bench for led_chain_driver: a cycle-count reference model predicts
// frames, acks, busy and blank; a pin monitor decodes frames and compares.
`timescale 1ns/1ps
module tb_led_chain_driver;

    localparam int NUM_LEDS     = 8;
    localparam int SLOT_BITS    = 2;
    localparam int CLK_DIV      = 4;
    localparam int BLINK_LOG2   = 8;
    localparam int FB           = NUM_LEDS * SLOT_BITS;
    localparam int BUSY_LEN     = 1 + (2*FB + 2) * CLK_DIV;
    localparam int BLINK_PERIOD = 1 << BLINK_LOG2;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n = 1'b0;
    logic [2*NUM_LEDS-1:0] led_mode = '0;
    logic                  write_request = 1'b0;
    logic                  blank = 1'b1;
    logic                  write_ack, busy, led_sck, led_sin, led_lat, led_blk;

    typedef struct {
        logic [FB-1:0] bits;
        int            rise_cycle;
        int            lat_cycle;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    int                    m_cycle, m_free_at, m_load_at, m_first_lat_end, m_c;
    logic [2*NUM_LEDS-1:0] m_shadow, m_next_shadow;
    bit                    m_pending, m_have_first, m_start, m_blink_any;
    frame_t                m_item;
    logic                  exp_ack, exp_busy, exp_blk;
    bit                    blank_random = 1'b0;

    int            mon_bits, mon_first_rise, mon_lat_len;
    logic [FB-1:0] mon_frame;
    bit            prev_sck, prev_lat, mon_lat_sck;
    frame_t        mon_item;

    led_chain_driver #(
        .NUM_LEDS(NUM_LEDS), .SLOT_BITS(SLOT_BITS), .CLK_DIV(CLK_DIV), .BLINK_LOG2(BLINK_LOG2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .led_mode(led_mode),
        .write_request(write_request), .write_ack(write_ack), .busy(busy),
        .blank(blank), .led_sck(led_sck), .led_sin(led_sin),
        .led_lat(led_lat), .led_blk(led_blk)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame content from the mode rules: per LED, SLOT_BITS-1 zeros then the value.
    function automatic logic [FB-1:0] expectedFrame(input logic [2*NUM_LEDS-1:0] modes, input bit ph);
        logic [FB-1:0] f;
        bit v;
        f = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (modes[2*i +: 2])
                2'b00:   v = 1'b0;
                2'b01:   v = 1'b1;
                2'b10:   v = ph;
                default: v = !ph;
            endcase
            for (int s = 0; s < SLOT_BITS - 1; s++) f = f << 1;
            f = (f << 1) | FB'(v);
        end
        return f;
    endfunction

    // Reference model, stepped once per clock; m_cycle counts cycles since reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_cycle = 0; m_free_at = 0; m_load_at = -1; m_first_lat_end = 0;
            m_shadow = '0; m_pending = 1'b0; m_have_first = 1'b0;
            exp_ack = 1'b0; exp_busy = 1'b0; exp_blk = 1'b1;
            exp_q.delete();
        end else begin
            m_c = m_cycle;
            m_blink_any = 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) m_blink_any = m_blink_any | m_shadow[2*i+1];
            m_next_shadow = m_shadow;
            m_start = 1'b0;
            exp_ack = 1'b0;
            if (m_c >= m_free_at) begin
                if (write_request) begin
                    m_next_shadow = led_mode;
                    exp_ack = 1'b1;
                    m_start = 1'b1;
                end else if (m_pending) begin
                    m_start = 1'b1;
                end
            end
            if (m_c == m_load_at) begin
                m_item.bits       = expectedFrame(m_shadow, bit'((m_c >> BLINK_LOG2) & 1));
                m_item.rise_cycle = m_c + 1 + CLK_DIV;
                m_item.lat_cycle  = m_c + 1 + 2*FB*CLK_DIV;
                exp_q.push_back(m_item);
                m_pending = 1'b0;
            end
            if (m_start) begin
                m_load_at = m_c + 1;
                m_free_at = m_c + 1 + BUSY_LEN;
                if (!m_have_first) begin
                    m_have_first = 1'b1;
                    m_first_lat_end = m_c + 1 + (2*FB + 1)*CLK_DIV;
                end
            end
            if (((m_c + 1) % BLINK_PERIOD) == 0 && m_blink_any) m_pending = 1'b1;
            exp_blk  = (m_have_first && m_c >= m_first_lat_end) ? blank : 1'b1;
            m_shadow = m_next_shadow;
            m_cycle  = m_c + 1;
            exp_busy = (m_cycle < m_free_at);
        end
    end

    // Pin monitor: per-cycle handshake/blank checks, frame decode on SCK rises.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            mon_bits = 0; mon_frame = '0; prev_sck = 1'b0; prev_lat = 1'b0;
        end else begin
            checkOutput("write_ack", 64'(write_ack), 64'(exp_ack));
            checkOutput("busy", 64'(busy), 64'(exp_busy));
            checkOutput("led_blk", 64'(led_blk), 64'(exp_blk));
            if (led_sck && !prev_sck) begin
                if (mon_bits == 0) mon_first_rise = m_cycle;
                mon_frame = (mon_frame << 1) | FB'(led_sin);
                mon_bits++;
            end
            if (led_lat && !prev_lat) begin
                mon_lat_len = 0;
                mon_lat_sck = 1'b0;
                checkOutput("latch_has_expected_frame", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_item = exp_q.pop_front();
                    checkOutput("frame_bits", 64'(mon_frame), 64'(mon_item.bits));
                    checkOutput("bit_count", 64'(mon_bits), FB);
                    checkOutput("first_rise_cycle", 64'(mon_first_rise), 64'(mon_item.rise_cycle));
                    checkOutput("latch_start_cycle", 64'(m_cycle), 64'(mon_item.lat_cycle));
                end
                mon_bits = 0;
                mon_frame = '0;
            end
            if (led_lat) begin
                mon_lat_len++;
                if (led_sck) mon_lat_sck = 1'b1;
            end
            if (!led_lat && prev_lat) begin
                checkOutput("latch_length", 64'(mon_lat_len), CLK_DIV);
                checkOutput("sck_in_latch", 64'(mon_lat_sck), 0);
            end
            prev_sck = led_sck;
            prev_lat = led_lat;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
        if (blank_random) blank = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [2*NUM_LEDS-1:0] mode);
        bit got;
        got = 1'b0;
        led_mode = mode;
        write_request = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            if (write_ack) got = 1'b1;
        end
        checkOutput("ack_within_bound", 64'(got), 1);
        write_request = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        checkOutput("idle_within_bound", 64'(done), 1);
    endtask

    task automatic checkReset();
        checkOutput("reset_sck", 64'(led_sck), 0);
        checkOutput("reset_sin", 64'(led_sin), 0);
        checkOutput("reset_lat", 64'(led_lat), 0);
        checkOutput("reset_blk", 64'(led_blk), 1);
        checkOutput("reset_ack", 64'(write_ack), 0);
        checkOutput("reset_busy", 64'(busy), 0);
    endtask

    initial begin
        bit reached;
        #23;
        checkReset();
        @(negedge sys_clk); #2; sys_rst_n = 1'b1;

        // Blank has no effect on led_blk before the first latch.
        repeat (10) tick();
        blank = 1'b0;
        repeat (10) tick();

        applyStimulus(16'h5555);
        waitIdle();
        blank_random = 1'b1;
        applyStimulus(16'h0001);
        waitIdle();
        applyStimulus(16'h4000);
        waitIdle();

        applyStimulus(16'h0020);
        repeat (800) tick();
        applyStimulus(16'h0030);
        repeat (800) tick();

        // Random modes with random gaps; many requests land mid-frame.
        for (int n = 0; n < 12; n++) begin
            applyStimulus(16'($urandom));
            repeat ($urandom_range(0, 150)) tick();
        end
        waitIdle();

        // Abort a frame after five bits have been clocked out.
        blank_random = 1'b0;
        applyStimulus(16'h5555);
        reached = 1'b0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            tick();
            if (mon_bits >= 5) reached = 1'b1;
        end
        checkOutput("reached_bit5", 64'(reached), 1);
        sys_rst_n = 1'b0;
        #1;
        checkReset();
        repeat (2) tick();
        @(negedge sys_clk); #2; sys_rst_n = 1'b1;
        blank = 1'b0;
        repeat (20) tick();

        blank_random = 1'b1;
        applyStimulus(16'($urandom));
        waitIdle();
        applyStimulus(16'h0000);
        waitIdle();
        repeat (300) tick();
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
